// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store (DM).
// At most one transaction in flight; DM has priority, bounded by a starvation counter.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic                o_if_gnt,
  output logic                o_if_rvalid,
  output logic [DATA_W-1:0]   o_if_rdata,
  input  logic                i_dm_req,
  input  logic                i_dm_we,
  input  logic [ADDR_W-1:0]   i_dm_addr,
  input  logic [DATA_W-1:0]   i_dm_wdata,
  input  logic [DATA_W/8-1:0] i_dm_mask,
  output logic                o_dm_gnt,
  output logic                o_dm_rvalid,
  output logic [DATA_W-1:0]   o_dm_rdata,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_mask,
  input  logic                i_mem_gnt,
  input  logic                i_mem_rvalid,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  input  logic                i_halt,
  output logic                o_busy,
  output logic                o_halted,
  output logic                o_err
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  state_t     state, state_next;
  logic       owner_dm;
  logic [3:0] starve_cnt;
  logic       halt_pend;
  logic       halted_q;
  logic       err_q;
  logic       if_forced;
  logic       pick_dm;
  logic       pick_if;
  logic       stray;
  logic       gnt_ok;
  logic       rsp_ok;
  logic       halt_cond;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // Memory handshake: o_mem_req is held with its fields until i_mem_gnt;
  // exactly one i_mem_rvalid follows each grant (possibly in the grant cycle).
  always_comb begin
    state_next = state;
    pick_dm    = 1'b0;
    pick_if    = 1'b0;
    stray      = 1'b0;
    if_forced  = i_if_req && !halt_pend && (starve_cnt == LIMIT);
    case (state)
      IDLE: begin
        if (i_dm_req && !if_forced) begin
          pick_dm    = 1'b1;
          state_next = REQ;
        end else if (i_if_req && !halt_pend) begin
          pick_if    = 1'b1;
          state_next = REQ;
        end
        stray = i_mem_rvalid || i_mem_gnt;
      end
      REQ: begin
        if (i_mem_gnt) state_next = i_mem_rvalid ? IDLE : RSP;
        else           stray      = i_mem_rvalid;
      end
      RSP: begin
        if (i_mem_rvalid) state_next = IDLE;
        stray = i_mem_gnt;
      end
      default: state_next = IDLE;
    endcase
  end

  assign gnt_ok    = (state == REQ) && i_mem_gnt;
  assign rsp_ok    = ((state == RSP) || gnt_ok) && i_mem_rvalid;
  assign halt_cond = halt_pend && (state == IDLE) && !i_dm_req;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      owner_dm    <= 1'b0;
      starve_cnt  <= '0;
      halt_pend   <= 1'b0;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_mask  <= '0;
    end else begin
      if (i_halt)    halt_pend <= 1'b1;
      if (halt_cond) halted_q  <= 1'b1;
      if (stray)     err_q     <= 1'b1;
      if (pick_dm) begin
        owner_dm    <= 1'b1;
        o_mem_req   <= 1'b1;
        o_mem_we    <= i_dm_we;
        o_mem_addr  <= i_dm_addr;
        o_mem_wdata <= i_dm_wdata;
        o_mem_mask  <= i_dm_we ? i_dm_mask : '1;
        if (!i_if_req)                starve_cnt <= '0;
        else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
      end else if (pick_if) begin
        owner_dm    <= 1'b0;
        o_mem_req   <= 1'b1;
        o_mem_we    <= 1'b0;
        o_mem_addr  <= i_if_addr;
        o_mem_wdata <= '0;
        o_mem_mask  <= '1;
        starve_cnt  <= '0;
      end else if (gnt_ok) begin
        o_mem_req <= 1'b0;
      end
    end
  end

  assign o_if_gnt    = gnt_ok && !owner_dm;
  assign o_dm_gnt    = gnt_ok && owner_dm;
  assign o_if_rvalid = rsp_ok && !owner_dm;
  assign o_dm_rvalid = rsp_ok && owner_dm;
  assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
  assign o_dm_rdata  = o_dm_rvalid ? i_mem_rdata : '0;
  assign o_busy      = (state != IDLE);
  assign o_halted    = halted_q || halt_cond;
  assign o_err       = err_q;

endmodule
